// File: rtl/invader_grid.sv
// invader_grid: 4x8 alien formation that marches across a 32-column field,
// descends at the edges, and is shot down one alien at a time by the player's
// bullet. Reports a one-cycle hit pulse, the alive bitmap, the formation
// position, the kill count, and the terminal WON / LOST conditions.
//
// Optional feature: define INVADER_SPEEDUP_EN to halve the step period once
// eight or fewer aliens remain. Without it the period is always MOVE_PERIOD
// and no alive-count logic exists.
module invader_grid #(
    parameter int MOVE_PERIOD = 9000000,
    parameter int LAND_ROW    = 11
) (
    input  logic        i_clk_36MHz,
    input  logic        i_reset,
    input  logic [4:0]  i_bullet_x,
    input  logic [3:0]  i_bullet_y,
    output logic        o_hit,
    output logic [31:0] o_alive,
    output logic [4:0]  o_grid_x,
    output logic [3:0]  o_grid_y,
    output logic [5:0]  o_score,
    output logic        o_all_dead,
    output logic        o_landed
);

    localparam int              CNT_W     = (MOVE_PERIOD > 2) ? $clog2(MOVE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(MOVE_PERIOD - 1);
`ifdef INVADER_SPEEDUP_EN
    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(MOVE_PERIOD / 2 - 1);
`endif
    localparam logic [4:0]      GRID_X_MAX = 5'd17;
    localparam logic [3:0]      LAND_Y     = 4'(LAND_ROW);
    localparam logic [3:0]      SHIP_ROW   = 4'd15;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WON  = 2'd1,
        S_LOST = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         grid_x_q, grid_x_d;
    logic [3:0]         grid_y_q, grid_y_d;
    logic               dir_left_q, dir_left_d;
    logic [31:0]        alive_q, alive_d;
    logic [5:0]         score_q, score_d;
    logic               hit_q, hit_d;
    logic               all_dead_q, all_dead_d;
    logic               landed_q, landed_d;
    logic               lh_valid_q, lh_valid_d;
    logic [4:0]         lh_x_q, lh_x_d;
    logic [3:0]         lh_y_q, lh_y_d;

    // Collision decode against the current (pre-step) formation position.
    logic [4:0]         dx;
    logic [3:0]         dy;
    logic               in_x, in_y;
    logic [4:0]         hit_idx;
    logic               same_pos;
    logic               collide;
    logic [CNT_W-1:0]   period_m1;
    logic               step_now;
    logic               descend;

`ifdef INVADER_SPEEDUP_EN
    // Number of aliens still alive; only needed to pick the faster period.
    function automatic logic [5:0] count_alive(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction
`endif

    // Bullet-to-alien hit detection, including the last-hit suppression latch.
    always_comb begin
        dx       = i_bullet_x - grid_x_q;
        dy       = i_bullet_y - grid_y_q;
        in_x     = (i_bullet_x >= grid_x_q) && (dx <= 5'd14) && !dx[0];
        in_y     = (i_bullet_y >= grid_y_q) && (dy <= 4'd3) && (i_bullet_y != SHIP_ROW);
        hit_idx  = {dy[1:0], dx[3:1]};
        same_pos = lh_valid_q && (i_bullet_x == lh_x_q) && (i_bullet_y == lh_y_q);
        collide  = (state_q == S_RUN) && in_x && in_y && alive_q[hit_idx] && !same_pos;
    end

    // Step period selection; a counter at or past the new period wraps next clock.
    always_comb begin
`ifdef INVADER_SPEEDUP_EN
        period_m1 = (count_alive(alive_q) <= 6'd8) ? HALF_M1 : PERIOD_M1;
        step_now  = (cnt_q >= period_m1);
`else
        period_m1 = PERIOD_M1;
        step_now  = (cnt_q == period_m1);
`endif
    end

    // Next-state logic: kills, formation march, and RUN/WON/LOST transitions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grid_x_d   = grid_x_q;
        grid_y_d   = grid_y_q;
        dir_left_d = dir_left_q;
        alive_d    = alive_q;
        score_d    = score_q;
        hit_d      = 1'b0;
        all_dead_d = all_dead_q;
        landed_d   = landed_q;
        lh_valid_d = lh_valid_q;
        lh_x_d     = lh_x_q;
        lh_y_d     = lh_y_q;
        descend    = 1'b0;

        if (state_q == S_RUN) begin
            // The latch only survives while the bullet stays put.
            lh_valid_d = same_pos;
            if (collide) begin
                alive_d[hit_idx] = 1'b0;
                score_d          = score_q + 6'd1;
                hit_d            = 1'b1;
                lh_valid_d       = 1'b1;
                lh_x_d           = i_bullet_x;
                lh_y_d           = i_bullet_y;
            end

            if (step_now) begin
                cnt_d = '0;
                if (!dir_left_q) begin
                    if (grid_x_q == GRID_X_MAX) begin
                        grid_y_d   = grid_y_q + 4'd1;
                        dir_left_d = 1'b1;
                        descend    = 1'b1;
                    end else begin
                        grid_x_d = grid_x_q + 5'd1;
                    end
                end else begin
                    if (grid_x_q == 5'd0) begin
                        grid_y_d   = grid_y_q + 4'd1;
                        dir_left_d = 1'b0;
                        descend    = 1'b1;
                    end else begin
                        grid_x_d = grid_x_q - 5'd1;
                    end
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // Clearing the last alien beats landing on the same edge.
            if (alive_d == 32'd0) begin
                state_d    = S_WON;
                all_dead_d = 1'b1;
            end else if (descend && (grid_y_d == LAND_Y)) begin
                state_d  = S_LOST;
                landed_d = 1'b1;
            end
        end
    end

    // State register; reset overrides any step or hit pending in the same cycle.
    always_ff @(posedge i_clk_36MHz) begin
        if (i_reset) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            grid_x_q   <= 5'd0;
            grid_y_q   <= 4'd0;
            dir_left_q <= 1'b0;
            alive_q    <= 32'hFFFF_FFFF;
            score_q    <= 6'd0;
            hit_q      <= 1'b0;
            all_dead_q <= 1'b0;
            landed_q   <= 1'b0;
            lh_valid_q <= 1'b0;
            lh_x_q     <= 5'd0;
            lh_y_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grid_x_q   <= grid_x_d;
            grid_y_q   <= grid_y_d;
            dir_left_q <= dir_left_d;
            alive_q    <= alive_d;
            score_q    <= score_d;
            hit_q      <= hit_d;
            all_dead_q <= all_dead_d;
            landed_q   <= landed_d;
            lh_valid_q <= lh_valid_d;
            lh_x_q     <= lh_x_d;
            lh_y_q     <= lh_y_d;
        end
    end

    assign o_hit      = hit_q;
    assign o_alive    = alive_q;
    assign o_grid_x   = grid_x_q;
    assign o_grid_y   = grid_y_q;
    assign o_score    = score_q;
    assign o_all_dead = all_dead_q;
    assign o_landed   = landed_q;

endmodule

// File: tb/tb_invader_grid.sv
// Self-checking bench for invader_grid: directed scenarios plus randomized
// bullets compared against a cell-search behavioural model of the game rules.
module tb_invader_grid;

    localparam int MP = 4;
    localparam int LR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  bx;
    logic [3:0]  by;
    logic        o_hit;
    logic [31:0] o_alive;
    logic [4:0]  o_grid_x;
    logic [3:0]  o_grid_y;
    logic [5:0]  o_score;
    logic        o_all_dead;
    logic        o_landed;

    int n_tests = 0;
    int n_fail  = 0;

    invader_grid #(.MOVE_PERIOD(MP), .LAND_ROW(LR)) dut (
        .i_clk_36MHz (clk),
        .i_reset     (rst),
        .i_bullet_x  (bx),
        .i_bullet_y  (by),
        .o_hit       (o_hit),
        .o_alive     (o_alive),
        .o_grid_x    (o_grid_x),
        .o_grid_y    (o_grid_y),
        .o_score     (o_score),
        .o_all_dead  (o_all_dead),
        .o_landed    (o_landed)
    );

    always #5 clk = ~clk;

    // Behavioural model: state 0=RUN, 1=WON, 2=LOST.
    int          m_gx, m_gy, m_cnt, m_score, m_state, m_lhx, m_lhy;
    bit          m_left, m_hit, m_lhv;
    logic [31:0] m_alive;

    task automatic model_clock();
        int  period;
        int  found;
        bit  descend;
        if (rst) begin
            m_gx = 0; m_gy = 0; m_cnt = 0; m_score = 0; m_state = 0;
            m_left = 0; m_hit = 0; m_lhv = 0; m_lhx = 0; m_lhy = 0;
            m_alive = 32'hFFFF_FFFF;
            return;
        end
        m_hit = 0;
        if (m_state != 0) return;
        period = MP;
`ifdef INVADER_SPEEDUP_EN
        if ($countones(m_alive) <= 8) period = MP / 2;
`endif
        found = -1;
        if (!(m_lhv && int'(bx) == m_lhx && int'(by) == m_lhy) && by != 4'd15) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 8; c++)
                    if (m_alive[r*8+c] && (m_gx + 2*c == int'(bx)) && (m_gy + r == int'(by)))
                        found = r*8 + c;
        end
        if (m_lhv && !(int'(bx) == m_lhx && int'(by) == m_lhy)) m_lhv = 0;
        if (found >= 0) begin
            m_alive[found] = 1'b0;
            m_score++;
            m_hit = 1;
            m_lhv = 1; m_lhx = int'(bx); m_lhy = int'(by);
        end
        descend = 0;
        if (m_cnt >= period - 1) begin
            m_cnt = 0;
            if (!m_left) begin
                if (m_gx == 17) begin m_gy++; m_left = 1; descend = 1; end
                else m_gx++;
            end else begin
                if (m_gx == 0) begin m_gy++; m_left = 0; descend = 1; end
                else m_gx--;
            end
        end else begin
            m_cnt++;
        end
        if (m_alive == 32'd0) m_state = 1;
        else if (descend && m_gy == LR) m_state = 2;
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bx = 5'd4; by = 4'd2;
        rst = 1'b0;
        tick();
        do_reset();
        n_tests++;
        if (o_alive !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_alive got %h exp ffffffff", o_alive); end
        n_tests++;
        if (o_grid_x !== 5'd0 || o_grid_y !== 4'd0) begin n_fail++; $display("FAIL reset_grid got %0d,%0d exp 0,0", o_grid_x, o_grid_y); end
        n_tests++;
        if (o_hit !== 1'b0 || o_score !== 6'd0 || o_all_dead !== 1'b0 || o_landed !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got hit=%b score=%0d dead=%b land=%b exp 0,0,0,0", o_hit, o_score, o_all_dead, o_landed);
        end
    endtask

    task automatic test_step();
        bx = 5'd31; by = 4'd15;
        do_reset();
        repeat (3) tick();
        n_tests++;
        if (o_grid_x !== 5'd0) begin n_fail++; $display("FAIL step_before got %0d exp 0", o_grid_x); end
        tick();
        n_tests++;
        if (o_grid_x !== 5'd1) begin n_fail++; $display("FAIL step_first got %0d exp 1", o_grid_x); end
        repeat (16 * MP) tick();
        n_tests++;
        if (o_grid_x !== 5'd17 || o_grid_y !== 4'd0) begin n_fail++; $display("FAIL step_right_edge got %0d,%0d exp 17,0", o_grid_x, o_grid_y); end
        repeat (MP) tick();
        n_tests++;
        if (o_grid_x !== 5'd17 || o_grid_y !== 4'd1) begin n_fail++; $display("FAIL step_descend got %0d,%0d exp 17,1", o_grid_x, o_grid_y); end
        repeat (MP) tick();
        n_tests++;
        if (o_grid_x !== 5'd16) begin n_fail++; $display("FAIL step_left got %0d exp 16", o_grid_x); end
    endtask

    task automatic test_hit();
        logic [31:0] exp_alive;
        do_reset();
        bx = 5'd4; by = 4'd2;
        tick();
        exp_alive = 32'hFFFF_FFFF & ~(32'd1 << 18);
        n_tests++;
        if (o_hit !== 1'b1 || o_alive !== exp_alive || o_score !== 6'd1) begin
            n_fail++; $display("FAIL hit_first got hit=%b alive=%h score=%0d exp 1 %h 1", o_hit, o_alive, o_score, exp_alive);
        end
        tick();
        n_tests++;
        if (o_hit !== 1'b0 || o_score !== 6'd1) begin n_fail++; $display("FAIL hit_hold got hit=%b score=%0d exp 0 1", o_hit, o_score); end
        by = 4'd1;
        tick();
        exp_alive = exp_alive & ~(32'd1 << 10);
        n_tests++;
        if (o_hit !== 1'b1 || o_alive !== exp_alive || o_score !== 6'd2) begin
            n_fail++; $display("FAIL hit_row1 got hit=%b alive=%h score=%0d exp 1 %h 2", o_hit, o_alive, o_score, exp_alive);
        end
        by = 4'd2;
        tick();
        n_tests++;
        if (o_hit !== 1'b0 || o_score !== 6'd2 || o_grid_x !== 5'd1) begin
            n_fail++; $display("FAIL hit_dead_return got hit=%b score=%0d gx=%0d exp 0 2 1", o_hit, o_score, o_grid_x);
        end
    endtask

    task automatic test_no_hit();
        do_reset();
        bx = 5'd3; by = 4'd0;
        tick();
        n_tests++;
        if (o_hit !== 1'b0 || o_alive !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL nohit_odd got hit=%b alive=%h exp 0 ffffffff", o_hit, o_alive); end
        bx = 5'd2; by = 4'd15;
        tick();
        n_tests++;
        if (o_hit !== 1'b0 || o_alive !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL nohit_ship got hit=%b alive=%h exp 0 ffffffff", o_hit, o_alive); end
    endtask

    task automatic test_step_and_reset_race();
        bx = 5'd31; by = 4'd15;
        do_reset();
        repeat (3) tick();
        bx = 5'd0; by = 4'd0;
        tick();
        n_tests++;
        if (o_hit !== 1'b1 || o_alive !== 32'hFFFF_FFFE || o_grid_x !== 5'd1) begin
            n_fail++; $display("FAIL race_step_hit got hit=%b alive=%h gx=%0d exp 1 fffffffe 1", o_hit, o_alive, o_grid_x);
        end
        bx = 5'd3; by = 4'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (o_hit !== 1'b0 || o_alive !== 32'hFFFF_FFFF || o_score !== 6'd0 || o_grid_x !== 5'd0) begin
            n_fail++; $display("FAIL race_reset got hit=%b alive=%h score=%0d gx=%0d exp 0 ffffffff 0 0", o_hit, o_alive, o_score, o_grid_x);
        end
    endtask

    task automatic test_clear_all();
        int hits_missed;
        int gx_won;
        hits_missed = 0;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                bx = 5'(m_gx + 2*c);
                by = 4'(m_gy + r);
                tick();
                if (o_hit !== 1'b1) hits_missed++;
            end
        end
        n_tests++;
        if (hits_missed != 0) begin n_fail++; $display("FAIL clear_hits got %0d missed exp 0", hits_missed); end
        n_tests++;
        if (o_score !== 6'd32 || o_all_dead !== 1'b1 || o_alive !== 32'd0 || o_landed !== 1'b0) begin
            n_fail++; $display("FAIL clear_won got score=%0d dead=%b alive=%h land=%b exp 32 1 0 0", o_score, o_all_dead, o_alive, o_landed);
        end
        gx_won = m_gx;
        repeat (3 * MP) tick();
        n_tests++;
        if (o_grid_x !== 5'(gx_won) || o_grid_y !== 4'd0 || o_hit !== 1'b0 || o_all_dead !== 1'b1) begin
            n_fail++; $display("FAIL clear_frozen got gx=%0d gy=%0d hit=%b dead=%b exp %0d 0 0 1", o_grid_x, o_grid_y, o_hit, o_all_dead, gx_won);
        end
    endtask

    task automatic test_land();
        int budget;
        int late_hits;
        bx = 5'd31; by = 4'd15;
        do_reset();
        budget = 0;
        while (o_landed !== 1'b1 && budget < 400) begin
            tick();
            budget++;
        end
        n_tests++;
        if (o_landed !== 1'b1 || o_grid_y !== 4'd2 || o_grid_x !== 5'd0 || budget != 36 * MP) begin
            n_fail++; $display("FAIL land_reach got land=%b gy=%0d gx=%0d clocks=%0d exp 1 2 0 %0d", o_landed, o_grid_y, o_grid_x, budget, 36 * MP);
        end
        late_hits = 0;
        for (int c = 0; c < 4; c++) begin
            bx = 5'(2*c);
            by = 4'(2 + (c % 2));
            tick();
            if (o_hit !== 1'b0) late_hits++;
        end
        n_tests++;
        if (late_hits != 0 || o_alive !== 32'hFFFF_FFFF || o_grid_y !== 4'd2) begin
            n_fail++; $display("FAIL land_frozen got hits=%0d alive=%h gy=%0d exp 0 ffffffff 2", late_hits, o_alive, o_grid_y);
        end
    endtask

    task automatic test_random();
        int pick;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = ((i % 300) == 299 || $urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
            pick = $urandom_range(0, 3);
            if (pick <= 1) begin
                bx = 5'((m_gx + 2 * $urandom_range(0, 7)) & 31);
                by = 4'((m_gy + $urandom_range(0, 3)) & 15);
            end else if (pick == 3) begin
                bx = 5'($urandom_range(0, 31));
                by = 4'($urandom_range(0, 15));
            end
            tick();
            n_tests++;
            if (o_hit !== m_hit) begin n_fail++; $display("FAIL rand_hit cyc %0d got %b exp %b", i, o_hit, m_hit); end
            n_tests++;
            if (o_alive !== m_alive) begin n_fail++; $display("FAIL rand_alive cyc %0d got %h exp %h", i, o_alive, m_alive); end
            n_tests++;
            if (o_grid_x !== 5'(m_gx) || o_grid_y !== 4'(m_gy)) begin
                n_fail++; $display("FAIL rand_grid cyc %0d got %0d,%0d exp %0d,%0d", i, o_grid_x, o_grid_y, m_gx, m_gy);
            end
            n_tests++;
            if (o_score !== 6'(m_score)) begin n_fail++; $display("FAIL rand_score cyc %0d got %0d exp %0d", i, o_score, m_score); end
            n_tests++;
            if (o_all_dead !== (m_state == 1) || o_landed !== (m_state == 2)) begin
                n_fail++; $display("FAIL rand_state cyc %0d got dead=%b land=%b exp state %0d", i, o_all_dead, o_landed, m_state);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bx  = 5'd31;
        by  = 4'd15;
        test_reset();
        test_step();
        test_hit();
        test_no_hit();
        test_step_and_reset_race();
        test_clear_all();
        test_land();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
